// File: rtl/acc_pkg.sv
// Shared types and constants for the multi-block hash controller.
// State encoding, control-word bit positions and status codes.
package acc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_BLK,
    S_WR_BUSY,
    S_INIT,
    S_UPD1,
    S_HASH,
    S_UPD2,
    S_NEXT,
    S_WR_HASH,
    S_WR_STATUS
  } state_t;

  localparam int HASH_W = 256;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_DOUBLE = 2;
  localparam int CTRL_NBLK   = 3;

  localparam logic [31:0] STAT_BUSY  = 32'h0000_0005;
  localparam logic [31:0] STAT_DONE  = 32'h0000_0002;
  localparam logic [31:0] STAT_ERR   = 32'h0000_000A;
  localparam logic [31:0] STAT_ABORT = 32'h0000_0012;

endpackage

// File: rtl/acc_multiblock_control_unit.sv
// Multi-block hash job sequencer: snoops CPU control stores, fetches
// blocks, steps the compression core and writes digest plus status back.
module acc_multiblock_control_unit
  import acc_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int LISTEN_W    = 32,
  parameter int RD_DATA_W   = 512,
  parameter int WR_DATA_W   = 32,
  parameter int HASH_CYCLES = 64,
  parameter int MAX_BLOCKS  = 4,
  parameter logic [ADDR_W-1:0] HCB_BASE      = 16'h1000,
  parameter logic [ADDR_W-1:0] BLK_STRIDE    = 16'h0040,
  parameter logic [ADDR_W-1:0] ACB_BASE      = 16'h5000,
  parameter logic [ADDR_W-1:0] ACB_H0_OFFSET = 16'h0008,
  parameter logic [ADDR_W-1:0] WR_STRIDE     = 16'h0004,
  localparam int BLK_W = $clog2(MAX_BLOCKS + 1),
  localparam int CNT_W = $clog2(HASH_CYCLES) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_listen_en,
  input  logic [ADDR_W-1:0]    mem_listen_addr,
  input  logic [LISTEN_W-1:0]  mem_listen_data,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [RD_DATA_W-1:0] mem_rd_data,
  input  logic                 mem_rd_data_valid,
  output logic                 mem_wr_en,
  output logic [ADDR_W-1:0]    mem_wr_addr,
  output logic [WR_DATA_W-1:0] mem_wr_data,
  input  logic                 mem_wr_done,
  output logic [RD_DATA_W-1:0] msg_block,
  output logic [BLK_W-1:0]     blk_sel,
  output logic                 ms_init,
  output logic                 ms_enable,
  output logic                 cm_is_hashing,
  output logic                 cm_update_A_H,
  output logic                 cm_update_H0_7,
  output logic                 cm_rst_hash_n,
  output logic                 should_save_hash,
  output logic                 hash_done,
  output logic                 busy,
  output logic [CNT_W-1:0]     cm_cycle_count,
  input  logic [HASH_W-1:0]    cm_out
);

  localparam int NW    = HASH_W / WR_DATA_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BLK_W-1:0]     r_blk;
  logic [IDX_W-1:0]     r_idx;
  logic [BLK_W-1:0]     r_nblk;
  logic                 r_dbl;
  logic                 r_pass;
  logic                 r_abort_pend;
  logic [WR_DATA_W-1:0] r_status;
  logic [RD_DATA_W-1:0] r_msg;

  logic                 r_rd_en;
  logic [ADDR_W-1:0]    r_rd_addr;
  logic                 r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [WR_DATA_W-1:0] r_wr_data;
  logic                 r_ms_init;
  logic                 r_ms_en;
  logic                 r_hashing;
  logic                 r_upd_ah;
  logic                 r_upd_h07;
  logic                 r_rst_hash_n;
  logic                 r_save;
  logic                 r_hash_done;
  logic                 r_busy;

  state_t               w_nxt;
  logic [CNT_W-1:0]     w_nxt_cnt;
  logic [BLK_W-1:0]     w_nxt_blk;
  logic [IDX_W-1:0]     w_nxt_idx;
  logic [BLK_W-1:0]     w_nxt_nblk;
  logic                 w_nxt_dbl;
  logic                 w_nxt_pass;
  logic [WR_DATA_W-1:0] w_nxt_status;

  logic                 w_ctrl;
  logic                 w_start;
  logic                 w_abort_in;
  logic                 w_abort;
  logic                 w_dbl_in;
  logic [BLK_W-1:0]     w_nblk_in;
  logic                 w_nblk_ok;
  logic [BLK_W:0]       w_blk_inc;
  logic                 w_more;
  logic                 w_fin;
  logic                 w_unused_ok;

  assign w_ctrl     = mem_listen_en && (mem_listen_addr == ACB_BASE);
  assign w_start    = w_ctrl && mem_listen_data[CTRL_START];
  assign w_abort_in = w_ctrl && mem_listen_data[CTRL_ABORT];
  assign w_dbl_in   = mem_listen_data[CTRL_DOUBLE];
  assign w_nblk_in  = mem_listen_data[CTRL_NBLK +: BLK_W];
  assign w_nblk_ok  = (w_nblk_in != '0) &&
                      (w_nblk_in <= BLK_W'(MAX_BLOCKS));
  assign w_abort    = r_abort_pend || w_abort_in;

  assign w_blk_inc  = {1'b0, r_blk} + 1'b1;
  assign w_more     = w_blk_inc < {1'b0, r_nblk};
  assign w_fin      = r_pass || (!r_dbl && !w_more);

  assign w_unused_ok = ^mem_listen_data;

  // Next-state and next-counter decode for the job sequencer
  always_comb begin
    w_nxt        = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_blk    = r_blk;
    w_nxt_idx    = r_idx;
    w_nxt_nblk   = r_nblk;
    w_nxt_dbl    = r_dbl;
    w_nxt_pass   = r_pass;
    w_nxt_status = r_status;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_nblk_ok) begin
            w_nxt      = S_RD_BLK;
            w_nxt_nblk = w_nblk_in;
            w_nxt_dbl  = w_dbl_in;
            w_nxt_blk  = '0;
            w_nxt_idx  = '0;
            w_nxt_pass = 1'b0;
            w_nxt_cnt  = '0;
          end else begin
            w_nxt        = S_WR_STATUS;
            w_nxt_status = WR_DATA_W'(STAT_ERR);
          end
        end
      end
      S_RD_BLK: begin
        if (mem_rd_data_valid)
          w_nxt = (r_blk == '0) ? S_WR_BUSY : S_UPD1;
      end
      S_WR_BUSY: begin
        if (mem_wr_done)
          w_nxt = S_INIT;
      end
      S_INIT: w_nxt = S_UPD1;
      S_UPD1: w_nxt = S_HASH;
      S_HASH: begin
        if (r_cnt < CNT_W'(HASH_CYCLES)) begin
          w_nxt_cnt = r_cnt + 1'b1;
        end else begin
          w_nxt_cnt = '0;
          w_nxt     = S_UPD2;
        end
      end
      S_UPD2: w_nxt = S_NEXT;
      S_NEXT: begin
        if (!r_pass && w_more) begin
          w_nxt_blk = w_blk_inc[BLK_W-1:0];
          w_nxt     = S_RD_BLK;
        end else if (!r_pass && r_dbl) begin
          w_nxt_blk  = BLK_W'(MAX_BLOCKS);
          w_nxt_pass = 1'b1;
          w_nxt      = S_INIT;
        end else begin
          w_nxt_idx = '0;
          w_nxt     = S_WR_HASH;
        end
      end
      S_WR_HASH: begin
        if (mem_wr_done) begin
          if (r_idx == IDX_W'(NW - 1)) begin
            w_nxt_idx    = '0;
            w_nxt_status = WR_DATA_W'(STAT_DONE);
            w_nxt        = S_WR_STATUS;
          end else begin
            w_nxt_idx = r_idx + 1'b1;
          end
        end
      end
      S_WR_STATUS: begin
        if (mem_wr_done)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_abort && (r_state inside
        {S_INIT, S_UPD1, S_HASH, S_UPD2, S_NEXT})) begin
      w_nxt        = S_WR_STATUS;
      w_nxt_status = WR_DATA_W'(STAT_ABORT);
      w_nxt_cnt    = '0;
      w_nxt_blk    = r_blk;
      w_nxt_pass   = r_pass;
    end
  end

  // State, counters, latched job fields and the fetched block
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_blk        <= '0;
      r_idx        <= '0;
      r_nblk       <= '0;
      r_dbl        <= 1'b0;
      r_pass       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_status     <= '0;
      r_msg        <= '0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_nxt_cnt;
      r_blk    <= w_nxt_blk;
      r_idx    <= w_nxt_idx;
      r_nblk   <= w_nxt_nblk;
      r_dbl    <= w_nxt_dbl;
      r_pass   <= w_nxt_pass;
      r_status <= w_nxt_status;
      if (w_nxt == S_IDLE)
        r_abort_pend <= 1'b0;
      else if (r_state != S_IDLE && w_abort_in)
        r_abort_pend <= 1'b1;
      if (r_state == S_RD_BLK && mem_rd_data_valid)
        r_msg <= mem_rd_data;
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_ms_init    <= 1'b0;
      r_ms_en      <= 1'b0;
      r_hashing    <= 1'b0;
      r_upd_ah     <= 1'b0;
      r_upd_h07    <= 1'b0;
      r_rst_hash_n <= 1'b1;
      r_save       <= 1'b0;
      r_hash_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rd_en   <= (w_nxt == S_RD_BLK);
      r_rd_addr <= (w_nxt == S_RD_BLK) ?
                   HCB_BASE + ADDR_W'(w_nxt_blk) * BLK_STRIDE : '0;
      r_wr_en   <= (w_nxt == S_WR_BUSY) || (w_nxt == S_WR_HASH) ||
                   (w_nxt == S_WR_STATUS);
      unique case (1'b1)
        (w_nxt == S_WR_BUSY): begin
          r_wr_addr <= ACB_BASE;
          r_wr_data <= WR_DATA_W'(STAT_BUSY);
        end
        (w_nxt == S_WR_HASH): begin
          r_wr_addr <= ACB_BASE + ACB_H0_OFFSET +
                       ADDR_W'(w_nxt_idx) * WR_STRIDE;
          r_wr_data <= cm_out[w_nxt_idx * WR_DATA_W +: WR_DATA_W];
        end
        (w_nxt == S_WR_STATUS): begin
          r_wr_addr <= ACB_BASE;
          r_wr_data <= w_nxt_status;
        end
        default: begin
          r_wr_addr <= '0;
          r_wr_data <= '0;
        end
      endcase
      r_ms_init    <= (w_nxt == S_UPD1);
      r_upd_ah     <= (w_nxt == S_UPD1);
      r_hashing    <= (w_nxt == S_HASH) &&
                      (w_nxt_cnt < CNT_W'(HASH_CYCLES));
      r_ms_en      <= (w_nxt == S_HASH) &&
                      (w_nxt_cnt < CNT_W'(HASH_CYCLES));
      r_upd_h07    <= (w_nxt == S_UPD2);
      r_rst_hash_n <= (w_nxt != S_INIT);
      r_save       <= (w_nxt == S_NEXT);
      r_hash_done  <= (w_nxt == S_NEXT) && w_fin;
      r_busy       <= (w_nxt != S_IDLE);
    end
  end

  assign mem_rd_en        = r_rd_en;
  assign mem_rd_addr      = r_rd_addr;
  assign mem_wr_en        = r_wr_en;
  assign mem_wr_addr      = r_wr_addr;
  assign mem_wr_data      = r_wr_data;
  assign msg_block        = r_msg;
  assign blk_sel          = r_blk;
  assign ms_init          = r_ms_init;
  assign ms_enable        = r_ms_en;
  assign cm_is_hashing    = r_hashing;
  assign cm_update_A_H    = r_upd_ah;
  assign cm_update_H0_7   = r_upd_h07;
  assign cm_rst_hash_n    = r_rst_hash_n;
  assign should_save_hash = r_save;
  assign hash_done        = r_hash_done;
  assign busy             = r_busy;
  assign cm_cycle_count   = r_cnt;

endmodule
